// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the write port of a dual-clock FIFO among NREQ requesters using
//   round-robin arbitration. A grant is held for a burst of up to MAX_BURST
//   beats, and the FIFO clear is sequenced for CLR_CYCLES cycles on request.
//   Everything runs in the write-clock domain.
//
// Ports
//   wr_clk     write clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   req_valid  per-requester "beat available"
//   req_data   requester i data at [i*DW +: DW]
//   req_ready  per-requester "beat accepted this cycle"
//   clr_req    single-cycle pulse requesting a FIFO clear
//   clr_busy   high while the clear sequence runs
//   grant_id   index of the current / last grantee (round-robin pointer)
//   fifo_din   FIFO write data (pass-through of the grantee's data)
//   fifo_we    FIFO write enable
//   fifo_full  FIFO full flag (write-clock domain)
//   fifo_clr   FIFO clear
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 8,
    parameter int MAX_BURST  = 4,
    parameter int CLR_CYCLES = 2
) (
    input  logic                    wr_clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [DW-1:0]           fifo_din,
    output logic                    fifo_we,
    input  logic                    fifo_full,
    output logic                    fifo_clr
);

    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_CLEAR
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;

    logic [GW-1:0]   next_grant;
    logic [GW-1:0]   cand;
    logic            found;
    logic            beat;

    logic [DW-1:0]   req_data_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_data_a[i] = req_data[i*DW +: DW];
    end

    // Round-robin search: first valid requester after the current pointer,
    // wrapping around so the pointer itself is considered last.
    always_comb begin
        next_grant = grant_q;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(grant_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    // NOTE: every output and next-state value gets a default before the case
    //       statement, so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        burst_d   = burst_q;
        clr_cnt_d = clr_cnt_q;
        beat      = 1'b0;
        req_ready = '0;
        fifo_we   = 1'b0;
        fifo_din  = '0;
        fifo_clr  = 1'b0;
        clr_busy  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A clear request wins over arbitration; the pointer is left alone.
                if (clr_req) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end else if (|req_valid) begin
                    grant_d = next_grant;
                    state_d = S_GRANT;
                end
            end

            S_GRANT: begin
                beat               = req_valid[grant_q] & ~fifo_full;
                req_ready[grant_q] = beat;
                fifo_we            = beat;
                fifo_din           = req_data_a[grant_q];

                // The beat of this cycle is still written when a clear arrives.
                if (clr_req) begin
                    state_d   = S_CLEAR;
                    burst_d   = '0;
                    clr_cnt_d = '0;
                end else if (beat) begin
                    if (burst_q == BW'(MAX_BURST - 1)) begin
                        state_d = S_IDLE;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end else if (!req_valid[grant_q]) begin
                    state_d = S_IDLE;
                    burst_d = '0;
                end
                // valid & full: stall with grant and count held.
            end

            S_CLEAR: begin
                fifo_clr = 1'b1;
                clr_busy = 1'b1;
                if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = '0;
                    burst_d   = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples the pre-edge values of its peers.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= GW'(NREQ - 1);
            burst_q   <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            burst_q   <= burst_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter: directed scenarios with constant
//   expectations, a per-cycle behavioural model of the arbitration rules, and
//   a FIFO model with a 3x slower read clock feeding a data scoreboard.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NREQ       = 4;
    localparam int DW         = 8;
    localparam int MAX_BURST  = 4;
    localparam int CLR_CYCLES = 2;
    localparam int GW         = 2;
    localparam int DEPTH      = 8;

    logic               wr_clk = 1'b0;
    logic               rclk   = 1'b0;
    logic               rst    = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data  = '0;
    logic [NREQ-1:0]    req_ready;
    logic               clr_req = 1'b0;
    logic               clr_busy;
    logic [GW-1:0]      grant_id;
    logic [DW-1:0]      fifo_din;
    logic               fifo_we;
    logic               fifo_full;
    logic               fifo_clr;

    logic               full_drv   = 1'b0;
    logic               full_model = 1'b0;
    logic               sb_en      = 1'b0;
    logic               mon_en     = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int reads_ok = 0;
    int seq [NREQ];

    assign fifo_full = sb_en ? full_model : full_drv;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .wr_clk   (wr_clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .grant_id (grant_id),
        .fifo_din (fifo_din),
        .fifo_we  (fifo_we),
        .fifo_full(fifo_full),
        .fifo_clr (fifo_clr)
    );

    always #5 wr_clk = ~wr_clk;
    initial begin
        #7;
        forever #15 rclk = ~rclk;
    end

    // ---------------------------------------------------------------- model
    // Arbitration rules in plain terms: a pointer, whether someone holds the
    // port, beats taken in this burst, and clear cycles still to run.
    int   m_ptr      = NREQ - 1;
    bit   m_granted  = 1'b0;
    int   m_burst    = 0;
    int   m_clr_left = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] dut_q [$];

    function automatic logic m_beat();
        return (m_clr_left == 0) && m_granted && req_valid[m_ptr] && !fifo_full;
    endfunction

    task automatic model_step();
        int nxt;
        bit hit;
        if (rst) begin
            m_ptr = NREQ - 1; m_granted = 1'b0; m_burst = 0; m_clr_left = 0;
        end else if (m_clr_left > 0) begin
            if (sb_en) exp_q.delete();
            m_clr_left--;
        end else begin
            if (m_beat() && sb_en) exp_q.push_back(req_data[m_ptr*DW +: DW]);
            if (clr_req) begin
                m_clr_left = CLR_CYCLES; m_granted = 1'b0; m_burst = 0;
            end else if (!m_granted) begin
                hit = 1'b0; nxt = m_ptr;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!hit && req_valid[(m_ptr + k) % NREQ]) begin
                        nxt = (m_ptr + k) % NREQ; hit = 1'b1;
                    end
                end
                m_ptr = nxt; m_granted = hit;
            end else if (m_beat()) begin
                m_burst++;
                if (m_burst == MAX_BURST) begin m_granted = 1'b0; m_burst = 0; end
            end else if (!req_valid[m_ptr]) begin
                m_granted = 1'b0; m_burst = 0;
            end
        end
    endtask

    always @(posedge wr_clk) model_step();

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge wr_clk) begin
        logic            e_we;
        logic [NREQ-1:0] e_rdy;
        logic            e_clr;
        logic [DW-1:0]   e_din;
        if (mon_en) begin
            e_we  = m_beat();
            e_rdy = '0;
            if (e_we) e_rdy[m_ptr] = 1'b1;
            e_clr = (m_clr_left > 0);
            e_din = req_data[m_ptr*DW +: DW];
            vectors++;
            if (fifo_we !== e_we || req_ready !== e_rdy || fifo_clr !== e_clr ||
                clr_busy !== e_clr || grant_id !== GW'(m_ptr) ||
                (e_we && fifo_din !== e_din)) begin
                errors++;
                $display("FAIL model t=%0t we=%b exp %b ready=%b exp %b clr=%b busy=%b exp %b gid=%0d exp %0d din=%h exp %h",
                         $time, fifo_we, e_we, req_ready, e_rdy, fifo_clr, clr_busy, e_clr,
                         grant_id, m_ptr, fifo_din, e_din);
            end
        end
    end

    // FIFO write side: holds what the DUT writes; full is registered so a
    // write of cycle t shows up as full in cycle t+1.
    always @(posedge wr_clk) begin
        if (sb_en) begin
            if (fifo_clr) begin
                dut_q.delete();
            end else if (fifo_we) begin
                vectors++;
                if (dut_q.size() >= DEPTH) begin
                    errors++;
                    $display("FAIL overflow t=%0t size=%0d limit %0d", $time, dut_q.size(), DEPTH);
                end else begin
                    dut_q.push_back(fifo_din);
                end
            end
            full_model <= (dut_q.size() >= DEPTH);
        end
    end

    // FIFO read side on the slow clock: compare dout with the model stream.
    always @(posedge rclk) begin
        logic [DW-1:0] d, e;
        if (sb_en && dut_q.size() > 0) begin
            d = dut_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra t=%0t dout=%h expected nothing", $time, d);
            end else begin
                e = exp_q.pop_front();
                if (d !== e) begin
                    errors++;
                    $display("FAIL sb_data t=%0t dout=%h exp %h", $time, d, e);
                end else begin
                    reads_ok++;
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(posedge wr_clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; clr_req = 1'b0; full_drv = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++)
            req_data[i*DW +: DW] = DW'((i << 6) | (seq[i] & 63));
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1; req_valid = '0; clr_req = 1'b0; full_drv = 1'b0;
        repeat (2) step();
        #2;
        vectors++;
        if ({req_ready, fifo_we, fifo_clr, clr_busy} !== '0 || grant_id !== GW'(NREQ - 1)) begin
            errors++;
            $display("FAIL reset ready=%b we=%b clr=%b busy=%b gid=%0d exp 0/0/0/0/%0d",
                     req_ready, fifo_we, fifo_clr, clr_busy, grant_id, NREQ - 1);
        end
        mon_en = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        logic [8:0] pat = 9'h0DE;
        int sent = 0;
        int exp_n = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req_valid = (sent < 6) ? 4'b0001 : 4'b0000;
            req_data  = '0;
            req_data[7:0] = 8'hA0 + 8'(sent);
            #2;
            vectors++;
            if (fifo_we !== pat[c] || (pat[c] && fifo_din !== 8'hA0 + 8'(exp_n))) begin
                errors++;
                $display("FAIL single_burst c=%0d we=%b exp %b din=%h exp %h",
                         c, fifo_we, pat[c], fifo_din, 8'hA0 + 8'(exp_n));
            end
            if (req_ready[0]) sent++;
            if (pat[c]) exp_n++;
            step();
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_round_robin();
        int r, ph, g, es;
        logic [NREQ-1:0] er;
        do_reset();
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        req_valid = 4'hF;
        for (int c = 0; c < 25; c++) begin
            drive_data();
            #2;
            r = c / 5; ph = c % 5; g = r % NREQ; es = (r / NREQ) * MAX_BURST + ph - 1;
            er = '0;
            if (ph != 0) er[g] = 1'b1;
            vectors++;
            if (ph == 0) begin
                if (fifo_we !== 1'b0 || req_ready !== '0) begin
                    errors++;
                    $display("FAIL rr_bubble c=%0d we=%b ready=%b exp 0/0000", c, fifo_we, req_ready);
                end
            end else if (fifo_we !== 1'b1 || grant_id !== GW'(g) || req_ready !== er ||
                         fifo_din !== DW'((g << 6) | es)) begin
                errors++;
                $display("FAIL rr_beat c=%0d we=%b gid=%0d exp %0d ready=%b exp %b din=%h exp %h",
                         c, fifo_we, grant_id, g, req_ready, er, fifo_din, DW'((g << 6) | es));
            end
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) seq[i]++;
            step();
        end
        req_valid = '0;
        vectors++;
        if (seq[0] != 8 || seq[1] != 4 || seq[2] != 4 || seq[3] != 4) begin
            errors++;
            $display("FAIL rr_counts got %0d/%0d/%0d/%0d exp 8/4/4/4", seq[0], seq[1], seq[2], seq[3]);
        end
        repeat (2) step();
    endtask

    task automatic test_full_stall();
        logic [9:0] pat = 10'h2E2;
        logic [NREQ-1:0] er;
        logic [DW-1:0]   ed;
        do_reset();
        req_valid = 4'b0011;
        req_data  = '0;
        req_data[7:0]  = 8'h11;
        req_data[15:8] = 8'h22;
        for (int c = 0; c < 10; c++) begin
            full_drv = (c >= 2 && c <= 4);
            #2;
            er = '0;
            if (pat[c]) er[(c == 9) ? 1 : 0] = 1'b1;
            ed = (c == 9) ? 8'h22 : 8'h11;
            vectors++;
            if (fifo_we !== pat[c] || req_ready !== er || (pat[c] && fifo_din !== ed) ||
                (c >= 1 && grant_id !== ((c == 9) ? GW'(1) : GW'(0)))) begin
                errors++;
                $display("FAIL full_stall c=%0d we=%b exp %b ready=%b exp %b din=%h exp %h gid=%0d",
                         c, fifo_we, pat[c], req_ready, er, fifo_din, ed, grant_id);
            end
            step();
        end
        req_valid = '0; full_drv = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_clear();
        logic [6:0] we_pat  = 7'h46;
        logic [6:0] clr_pat = 7'h18;
        do_reset();
        req_valid = 4'b0011;
        req_data  = '0;
        req_data[7:0]  = 8'h11;
        req_data[15:8] = 8'h22;
        for (int c = 0; c < 7; c++) begin
            clr_req = (c == 2 || c == 4);
            #2;
            vectors++;
            if (fifo_we !== we_pat[c] || fifo_clr !== clr_pat[c] || clr_busy !== clr_pat[c] ||
                (!we_pat[c] && req_ready !== '0) || (c == 2 && fifo_din !== 8'h11) ||
                (c == 5 && grant_id !== GW'(0)) ||
                (c == 6 && (grant_id !== GW'(1) || req_ready !== 4'b0010))) begin
                errors++;
                $display("FAIL clear c=%0d we=%b exp %b clr=%b busy=%b exp %b ready=%b gid=%0d din=%h",
                         c, fifo_we, we_pat[c], fifo_clr, clr_busy, clr_pat[c], req_ready, grant_id, fifo_din);
            end
            step();
        end
        clr_req = 1'b0; req_valid = '0;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0100;
        step();
        #2;
        vectors++;
        if (fifo_we !== 1'b1 || grant_id !== GW'(2)) begin
            errors++;
            $display("FAIL rst_pre c=1 we=%b gid=%0d exp 1/2", fifo_we, grant_id);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 4'hF;
        #2;
        vectors++;
        if ({req_ready, fifo_we, fifo_clr, clr_busy} !== '0 || fifo_din !== '0 || grant_id !== GW'(3)) begin
            errors++;
            $display("FAIL rst_burst ready=%b we=%b clr=%b busy=%b din=%h gid=%0d exp all 0, gid 3",
                     req_ready, fifo_we, fifo_clr, clr_busy, fifo_din, grant_id);
        end
        step();
        #2;
        vectors++;
        if (fifo_we !== 1'b1 || grant_id !== GW'(0) || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_first_grant we=%b gid=%0d ready=%b exp 1/0/0001", fifo_we, grant_id, req_ready);
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        #2;
        vectors++;
        if (fifo_clr !== 1'b1 || clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_clr_enter clr=%b busy=%b exp 1/1", fifo_clr, clr_busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        vectors++;
        if ({req_ready, fifo_we, fifo_clr, clr_busy} !== '0 || grant_id !== GW'(3)) begin
            errors++;
            $display("FAIL rst_clear ready=%b we=%b clr=%b busy=%b gid=%0d exp all 0, gid 3",
                     req_ready, fifo_we, fifo_clr, clr_busy, grant_id);
        end
        step();
        #2;
        vectors++;
        if (fifo_we !== 1'b1 || grant_id !== GW'(0)) begin
            errors++;
            $display("FAIL rst_clr_regrant we=%b gid=%0d exp 1/0", fifo_we, grant_id);
        end
        req_valid = '0;
        repeat (2) step();
    endtask

    task automatic test_random();
        do_reset();
        dut_q.delete();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        sb_en = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(0, 9) < 7);
            clr_req = ($urandom_range(0, 79) == 0);
            drive_data();
            #2;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) seq[i]++;
            step();
        end
        clr_req = 1'b0; req_valid = '0;
        repeat (60) step();
        vectors++;
        if (exp_q.size() != 0 || dut_q.size() != 0 || reads_ok < 100) begin
            errors++;
            $display("FAIL sb_drain exp_left=%0d fifo_left=%0d reads=%0d exp 0/0/>=100",
                     exp_q.size(), dut_q.size(), reads_ok);
        end
        sb_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
